// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction stream loader.
// No logic; pure declarations.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_WAIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0013;

    // Number of byte-address bits below the word index.
    function automatic int ADDR_LSB(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/inst_mem_1r1w.sv
// Synchronous 1R1W RAM, DEPTH x DATA_WIDTH; read data registered, 1-cycle latency.
// No backpressure: one write and one read may be issued every cycle.
module inst_mem_1r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_stream_loader.sv
// Streams a program into local RAM, then serves core fetches (1-cycle latency) until it runs off the end.
// Backpressure: load_ready is high only while loading; fetches are never stalled.
module inst_stream_loader
    import inst_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(DEFAULT_NOP_WORD),
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    input  logic [DATA_WIDTH-1:0]     load_data,
    input  logic                      load_last,
    output logic                      load_ready,
    input  logic                      start,
    output logic                      core_rst_n,
    input  logic [DATA_WIDTH-1:0]     inst_address,
    output logic [DATA_WIDTH-1:0]     inst,
    output logic                      inst_valid,
    output logic [$clog2(DEPTH):0]    prog_len,
    output logic [CNT_WIDTH-1:0]      fetch_count,
    output logic                      done,
    output logic                      err_overflow,
    output logic                      err_misalign
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int CMW = (DATA_WIDTH > LW) ? DATA_WIDTH : LW;
    localparam int LSB = ADDR_LSB(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'((64'd1 << LSB) - 64'd1);

    state_t                state;
    logic [LW-1:0]         len_q;
    logic                  valid_q;
    logic                  accept;
    logic                  full;
    logic                  hit;
    logic [DATA_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign accept = load_valid && load_ready;
    assign full   = (len_q == LW'(DEPTH));
    assign idx    = inst_address >> LSB;
    assign hit    = CMW'(idx) < CMW'(len_q);

    assign load_ready = (state == S_LOAD);
    assign core_rst_n = (state == S_RUN);
    assign prog_len   = len_q;
    assign inst_valid = valid_q;
    // Misses, reset and DONE all clear valid_q, which forces the NOP word out.
    assign inst       = valid_q ? ram_rdata : NOP_WORD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_LOAD;
            len_q        <= '0;
            valid_q      <= 1'b0;
            fetch_count  <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (full) begin
                            err_overflow <= 1'b1;
                            state        <= S_WAIT;
                        end else begin
                            len_q <= len_q + 1'b1;
                            if (load_last) begin
                                state <= S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (fetch_count != '1) begin
                        fetch_count <= fetch_count + 1'b1;
                    end
                    if ((inst_address & LOW_MASK) != '0) begin
                        err_misalign <= 1'b1;
                    end
                    if (hit) begin
                        valid_q <= 1'b1;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    inst_mem_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (accept && !full),
        .wr_addr (AW'(len_q)),
        .wr_data (load_data),
        .rd_en   (state == S_RUN),
        .rd_addr (AW'(idx)),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_inst_stream_loader.sv
// Randomised bench for inst_stream_loader against a program-array reference model.
module tb_inst_stream_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int LW    = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_valid = 1'b0;
    logic           load_last = 1'b0;
    logic           start = 1'b0;
    logic [DW-1:0]  load_data = '0;
    logic [DW-1:0]  inst_address = '0;
    logic           load_ready, core_rst_n, inst_valid, done, err_overflow, err_misalign;
    logic [DW-1:0]  inst;
    logic [LW-1:0]  prog_len;
    logic [CW-1:0]  fetch_count;

    int checks = 0;
    int errors = 0;

    // Reference model: stored program plus the externally visible status.
    logic [31:0] mem_m [DEPTH];
    int          len_m;
    int          fc_m;
    bit          ovf_m, mis_m, done_m, run_m;
    logic [31:0] words_q [$];

    always #5 clk = ~clk;

    inst_stream_loader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NOP_WORD   (NOP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .start        (start),
        .core_rst_n   (core_rst_n),
        .inst_address (inst_address),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .prog_len     (prog_len),
        .fetch_count  (fetch_count),
        .done         (done),
        .err_overflow (err_overflow),
        .err_misalign (err_misalign)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        start = 1'b0;
        inst_address = '0;
        #1;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_fetch_count", fetch_count, 0);
        chk("rst_done", done, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_misalign", err_misalign, 0);
        step();
        rst = 1'b1;
        len_m = 0; fc_m = 0;
        ovf_m = 0; mis_m = 0; done_m = 0; run_m = 0;
    endtask

    task automatic fill_random(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Streams words_q; idle gaps carry random load_last/start that must be ignored.
    task automatic load_words(input bit use_last, input bit gaps);
        int n;
        n = words_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                load_valid = 1'b0;
                load_last = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                step();
            end
            chk("ld_ready", load_ready, 1);
            load_valid = 1'b1;
            load_data = words_q[i];
            load_last = use_last && (i == n - 1);
            start = 1'($urandom_range(0, 1));
            if (len_m < DEPTH) begin
                mem_m[len_m] = words_q[i];
                len_m++;
            end else begin
                ovf_m = 1;
            end
            step();
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        start = 1'b0;
        chk("ld_prog_len", prog_len, len_m);
        chk("ld_err_overflow", err_overflow, ovf_m);
        chk("ld_wait_ready", load_ready, 0);
        chk("ld_core_rst_n", core_rst_n, 0);
        step();
        chk("wait_hold_core_rst_n", core_rst_n, 0);
    endtask

    task automatic start_run(input int idle);
        for (int i = 0; i < idle; i++) begin
            step();
            chk("wait_core_rst_n", core_rst_n, 0);
            chk("wait_load_ready", load_ready, 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        run_m = 1; fc_m = 0;
        chk("run_core_rst_n", core_rst_n, 1);
        chk("run_first_valid", inst_valid, 0);
        chk("run_first_count", fetch_count, 0);
    endtask

    task automatic fetch(input logic [31:0] a);
        logic [31:0] ei;
        bit ev;
        inst_address = a;
        step();
        ei = NOP;
        ev = 0;
        if (run_m) begin
            if (fc_m < (1 << CW) - 1) fc_m++;
            if (a[1:0] != 2'b00) mis_m = 1;
            if ((a >> 2) < len_m) begin
                ei = mem_m[a >> 2];
                ev = 1;
            end else begin
                done_m = 1;
                run_m = 0;
            end
        end
        chk("f_inst", inst, ei);
        chk("f_inst_valid", inst_valid, ev);
        chk("f_done", done, done_m);
        chk("f_fetch_count", fetch_count, fc_m);
        chk("f_err_misalign", err_misalign, mis_m);
        chk("f_core_rst_n", core_rst_n, run_m);
        chk("f_load_ready", load_ready, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int n;
        #2;
        do_reset();

        // Basic program, run off the end, then frozen.
        words_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        load_words(1, 0);
        start_run(1);
        fetch(0); fetch(4); fetch(8); fetch(12);
        fetch(16);
        fetch(0); fetch(4);

        // Overflow: DEPTH+1 words, no last.
        do_reset();
        fill_random(DEPTH + 1);
        load_words(0, 0);
        start_run(2);
        for (int i = 0; i <= DEPTH; i++) fetch(32'(i * 4));

        // Gapped load, misaligned fetch, counter saturation.
        do_reset();
        fill_random(3);
        load_words(1, 1);
        start_run(0);
        fetch(6);
        for (int i = 0; i < 20; i++) fetch(32'($urandom_range(0, 2) * 4));
        fetch(12);

        // Reset mid-run, then reload a shorter program.
        do_reset();
        fill_random(4);
        load_words(1, 0);
        start_run(0);
        fetch(0); fetch(4);
        do_reset();
        fill_random(2);
        load_words(1, 1);
        start_run(0);
        fetch(0); fetch(4); fetch(8);

        repeat (30) begin
            do_reset();
            n = $urandom_range(1, DEPTH + 1);
            fill_random(n);
            load_words(n <= DEPTH, 1'($urandom_range(0, 1)));
            start_run($urandom_range(0, 3));
            for (int k = 0; k < 20; k++) begin
                if ($urandom_range(0, 9) < 8) begin
                    a = 32'($urandom_range(0, len_m - 1)) << 2;
                    if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
                end else begin
                    a = $urandom;
                end
                fetch(a);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
